// File: rtl/ita_msg_source.sv
// Message buffer + 14-segment font + marquee scroll for the 12-digit scanner.
// Returns the segment pattern for digit_idx one cycle after it is presented.
module ita_msg_source #(
  parameter int          MSG_DEPTH  = 32,
  parameter logic [23:0] SCROLL_DIV = 24'd6000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [6:0]  wr_char,
  input  logic        wr_last,
  input  logic        scroll_en,
  input  logic [3:0]  digit_idx,
  output logic [13:0] seg_code,
  output logic [5:0]  msg_len
);

  localparam int AW = $clog2(MSG_DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, COMMIT, SHOW} state_t;

  state_t          state, state_nxt;
  logic [5:0]      wr_ptr;
  logic [AW-1:0]   offset;
  logic [23:0]     div_cnt;
  logic [6:0]      mem [MSG_DEPTH];
  logic            acc;
  logic [AW-1:0]   wr_addr;
  logic [6:0]      sum;
  logic [AW-1:0]   rd_addr;
  logic            blank;

  function automatic logic [13:0] font(input logic [6:0] c);
    logic [6:0] u;
    u = (c >= 7'h61 && c <= 7'h7A) ? c - 7'h20 : c;
    case (u)
      7'h30: font = 14'b11111100001001;
      7'h31: font = 14'b01100000001000;
      7'h32: font = 14'b11011011000000;
      7'h33: font = 14'b11110011000000;
      7'h34: font = 14'b01100111000000;
      7'h35: font = 14'b10110111000000;
      7'h36: font = 14'b10111111000000;
      7'h37: font = 14'b11100000000000;
      7'h38: font = 14'b11111111000000;
      7'h39: font = 14'b11110111000000;
      7'h41: font = 14'b11101111000000;
      7'h42: font = 14'b11110001010010;
      7'h43: font = 14'b10011100000000;
      7'h44: font = 14'b11110000010010;
      7'h45: font = 14'b10011110000000;
      7'h46: font = 14'b10001110000000;
      7'h47: font = 14'b10111101000000;
      7'h48: font = 14'b01101111000000;
      7'h49: font = 14'b10010000010010;
      7'h4A: font = 14'b01111000000000;
      7'h4B: font = 14'b00001110001100;
      7'h4C: font = 14'b00011100000000;
      7'h4D: font = 14'b01101100101000;
      7'h4E: font = 14'b01101100100100;
      7'h4F: font = 14'b11111100000000;
      7'h50: font = 14'b11001111000000;
      7'h51: font = 14'b11111100000100;
      7'h52: font = 14'b11001111000100;
      7'h53: font = 14'b10110111000000;
      7'h54: font = 14'b10000000010010;
      7'h55: font = 14'b01111100000000;
      7'h56: font = 14'b00001100001001;
      7'h57: font = 14'b01101100000101;
      7'h58: font = 14'b00000000101101;
      7'h59: font = 14'b00000000101010;
      7'h5A: font = 14'b10010000001001;
      default: font = 14'b0;  // space and unsupported codes
    endcase
  endfunction

  assign acc     = wr_valid && wr_ready;
  assign wr_addr = (state == LOAD) ? wr_ptr[AW-1:0] : '0;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, SHOW: if (acc) state_nxt = wr_last ? COMMIT : LOAD;
      LOAD:       if (acc && (wr_last || wr_ptr == 6'(MSG_DEPTH-1))) state_nxt = COMMIT;
      COMMIT:     state_nxt = SHOW;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      msg_len  <= '0;
      offset   <= '0;
      div_cnt  <= '0;
      wr_ready <= 1'b0;
    end else begin
      state    <= state_nxt;
      // ready is registered so it drops exactly for the COMMIT cycle
      wr_ready <= (state_nxt != COMMIT);
      if (acc) wr_ptr <= 6'(wr_addr) + 6'd1;
      if (state == COMMIT) begin
        msg_len <= wr_ptr;
        offset  <= '0;
        div_cnt <= '0;
      end else if (acc && state != LOAD) begin
        msg_len <= '0;
      end else if (state == SHOW && scroll_en) begin
        if (div_cnt == SCROLL_DIV - 24'd1) begin
          div_cnt <= '0;
          if (msg_len > 6'd12)
            offset <= (6'(offset) + 6'd1 == msg_len) ? '0 : offset + AW'(1);
        end else begin
          div_cnt <= div_cnt + 24'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (acc) mem[wr_addr] <= wr_char;
  end

  // offset < msg_len and idx < msg_len whenever not blank, so one subtract wraps
  always_comb begin
    sum     = 7'(offset) + 7'(digit_idx);
    rd_addr = AW'((sum >= 7'(msg_len)) ? sum - 7'(msg_len) : sum);
    blank   = (state != SHOW) || (digit_idx > 4'd11) ||
              (msg_len <= 6'd12 && {2'b0, digit_idx} >= msg_len);
  end

  always_ff @(posedge clk) begin
    if (rst) seg_code <= '0;
    else     seg_code <= blank ? 14'b0 : font(mem[rd_addr]);
  end

endmodule

// File: tb/tb_ita_msg_source.sv
// Self-checking bench for ita_msg_source: directed steps plus randomized
// messages checked every cycle against a queue-based reference model.
module tb_ita_msg_source;
  localparam int          DEPTH = 32;
  localparam logic [23:0] DIV   = 24'd4;
  localparam int          DIVI  = 4;

  logic        clk = 1'b0;
  logic        rst, wr_valid, wr_ready, wr_last, scroll_en;
  logic [6:0]  wr_char;
  logic [3:0]  digit_idx;
  logic [13:0] seg_code;
  logic [5:0]  msg_len;

  always #5 clk = ~clk;

  ita_msg_source #(.MSG_DEPTH(DEPTH), .SCROLL_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_char(wr_char), .wr_last(wr_last), .scroll_en(scroll_en),
    .digit_idx(digit_idx), .seg_code(seg_code), .msg_len(msg_len)
  );

  int n_assert = 0;
  int n_fail   = 0;

  string       font_keys = "ABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789 ";
  logic [13:0] font_codes [37] = '{
    14'b11101111000000, 14'b11110001010010, 14'b10011100000000, 14'b11110000010010,
    14'b10011110000000, 14'b10001110000000, 14'b10111101000000, 14'b01101111000000,
    14'b10010000010010, 14'b01111000000000, 14'b00001110001100, 14'b00011100000000,
    14'b01101100101000, 14'b01101100100100, 14'b11111100000000, 14'b11001111000000,
    14'b11111100000100, 14'b11001111000100, 14'b10110111000000, 14'b10000000010010,
    14'b01111100000000, 14'b00001100001001, 14'b01101100000101, 14'b00000000101101,
    14'b00000000101010, 14'b10010000001001,
    14'b11111100001001, 14'b01100000001000, 14'b11011011000000, 14'b11110011000000,
    14'b01100111000000, 14'b10110111000000, 14'b10111111000000, 14'b11100000000000,
    14'b11111111000000, 14'b11110111000000,
    14'b00000000000000
  };

  // reference model: committed text, pending text, display window position
  int          mlen = 0;
  logic [6:0]  mbuf [DEPTH];
  logic [6:0]  pend [$];
  bit          committing = 0, loading = 0, showing = 0;
  int          moff = 0, mdiv = 0;
  logic        rdy_exp = 1'b0;
  logic [13:0] seg_exp = 14'b0;

  function automatic logic [13:0] font_of(input logic [6:0] c);
    byte u;
    u = byte'(c);
    if (u >= "a" && u <= "z") u = u - 8'd32;
    for (int k = 0; k < 37; k++)
      if (font_keys[k] == u) return font_codes[k];
    return 14'b0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic r, v, l, se;
    logic [6:0] c;
    int idx;
    logic [13:0] sn;
    bit acc;
    r = rst; v = wr_valid; l = wr_last; se = scroll_en; c = wr_char; idx = int'(digit_idx);
    sn = 14'b0;
    if (showing && mlen > 0 && idx <= 11 && !(mlen <= 12 && idx >= mlen))
      sn = font_of(mbuf[(moff + idx) % mlen]);
    acc = v && rdy_exp;
    @(posedge clk);
    #1;
    if (r) begin
      mlen = 0; pend.delete(); committing = 0; loading = 0; showing = 0;
      moff = 0; mdiv = 0; rdy_exp = 1'b0; seg_exp = 14'b0;
    end else begin
      seg_exp = sn;
      if (committing) begin
        mlen = pend.size();
        foreach (pend[k]) mbuf[k] = pend[k];
        moff = 0; mdiv = 0; showing = 1; committing = 0;
      end else if (acc) begin
        if (!loading) begin pend.delete(); mlen = 0; showing = 0; end
        pend.push_back(c);
        if (l || pend.size() == DEPTH) begin committing = 1; loading = 0; end
        else loading = 1;
      end else if (showing && se) begin
        mdiv++;
        if (mdiv == DIVI) begin
          mdiv = 0;
          if (mlen > 12) moff = (moff + 1) % mlen;
        end
      end
      rdy_exp = !committing;
    end
    chk("seg_code", 32'(seg_code), 32'(seg_exp));
    chk("msg_len",  32'(msg_len),  32'(mlen));
    chk("wr_ready", 32'(wr_ready), 32'(rdy_exp));
  endtask

  task automatic send(input logic [6:0] c, input logic last);
    int guard;
    bit took;
    guard = 0;
    wr_valid = 1'b1; wr_char = c; wr_last = last;
    do begin
      took = wr_ready;
      tick();
      guard++;
    end while (!took && guard < 20);
    chk("wr_accept", 32'(took), 32'd1);
    wr_valid = 1'b0; wr_last = 1'b0;
  endtask

  task automatic send_str(input string s, input bit last);
    byte b;
    for (int k = 0; k < s.len(); k++) begin
      b = s[k];
      send(b[6:0], last && (k == s.len() - 1));
    end
  endtask

  task automatic read(input int idx, input string tag, input logic [13:0] exp);
    digit_idx = 4'(idx);
    tick();
    chk(tag, 32'(seg_code), 32'(exp));
  endtask

  initial begin
    string charset;
    byte   b;
    int    len;
    bit    do_rst, implicit;

    charset = " abcdefghijklmnopqrstuvwxyzABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789#!.-";
    rst = 1'b1; wr_valid = 1'b0; wr_char = '0; wr_last = 1'b0;
    scroll_en = 1'b0; digit_idx = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("ready_after_rst", 32'(wr_ready), 32'd1);
    for (int i = 0; i < 12; i++) read(i, "reset_read", 14'b0);

    // "TO GO ALONE", no scroll
    send_str("TO GO ALONE", 1);
    chk("ready_in_commit", 32'(wr_ready), 32'd0);
    tick();
    chk("ready_after_commit", 32'(wr_ready), 32'd1);
    chk("len11", 32'(msg_len), 32'd11);
    read(0,  "idx0_T",  14'b10000000010010);
    read(3,  "idx3_G",  14'b10111101000000);
    read(10, "idx10_E", 14'b10011110000000);
    read(11, "idx11_blank", 14'b0);

    // 14-char marquee with SCROLL_DIV = 4
    scroll_en = 1'b1; digit_idx = 4'd0;
    send_str("ABCDEFGHIJKLMN", 1);
    tick();
    chk("len14", 32'(msg_len), 32'd14);
    tick();
    chk("scroll_start_A", 32'(seg_code), 32'(14'b11101111000000));
    repeat (54) tick();
    tick();
    chk("scroll_pre_wrap_N", 32'(seg_code), 32'(14'b01101100100100));
    tick();
    chk("scroll_wrap_A", 32'(seg_code), 32'(14'b11101111000000));
    scroll_en = 1'b0;

    // 32 chars without wr_last commit implicitly
    for (int k = 0; k < 32; k++) send(7'(8'h41 + 8'($urandom_range(0, 25))), 1'b0);
    chk("implicit_commit_ready", 32'(wr_ready), 32'd0);
    tick();
    chk("len32", 32'(msg_len), 32'd32);
    send(7'h6F, 1'b0);
    chk("len_drop", 32'(msg_len), 32'd0);
    send(7'h6B, 1'b1);
    tick();
    chk("len2", 32'(msg_len), 32'd2);
    read(0,  "lower_o", 14'b11111100000000);
    read(1,  "lower_k", 14'b00001110001100);
    read(2,  "short_blank", 14'b0);
    read(13, "idx13_blank", 14'b0);

    send_str("#", 1);
    tick();
    read(0, "hash_blank", 14'b0);

    // next message presented while COMMIT holds off the write
    send_str("AB", 1);
    send_str("L", 1);
    tick();
    chk("len1", 32'(msg_len), 32'd1);
    read(0, "held_L", 14'b00011100000000);

    // reset in the middle of a load
    send_str("TOTAL", 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_len0", 32'(msg_len), 32'd0);
    for (int i = 0; i < 12; i++) read(i, "rst_read", 14'b0);
    send_str("ALONE", 1);
    tick();
    read(0, "fresh_A", 14'b11101111000000);
    read(4, "fresh_E", 14'b10011110000000);

    // randomized messages, gaps, scrolling and occasional reset
    for (int m = 0; m < 20; m++) begin
      len      = $urandom_range(1, 32);
      implicit = (len == 32) && ($urandom_range(0, 1) == 1);
      do_rst   = ($urandom_range(0, 7) == 0);
      for (int k = 0; k < len; k++) begin
        repeat ($urandom_range(0, 2)) begin
          digit_idx = 4'($urandom_range(0, 15));
          scroll_en = 1'($urandom_range(0, 1));
          tick();
        end
        if (do_rst && k == len / 2) begin
          rst = 1'b1; tick(); rst = 1'b0;
          break;
        end
        b = charset[$urandom_range(0, charset.len() - 1)];
        digit_idx = 4'($urandom_range(0, 15));
        send(b[6:0], !implicit && (k == len - 1));
      end
      repeat ($urandom_range(10, 60)) begin
        digit_idx = 4'($urandom_range(0, 15));
        scroll_en = ($urandom_range(0, 3) != 0);
        tick();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
